// File: rtl/iob_rr_arbiter.sv
// iob_rr_arbiter: N-master to 1-slave IOb arbiter with round-robin grant.
// Outstanding read IDs are kept in a small FIFO so read data returning
// in order from the slave is steered back to the master that issued it.
module iob_rr_arbiter #(
    parameter int N_MASTERS     = 2,
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int RD_FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [N_MASTERS-1:0]          m_avalid_i,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr_i,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata_i,
    input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb_i,
    output logic [N_MASTERS*DATA_W-1:0]   m_rdata_o,
    output logic [N_MASTERS-1:0]          m_rvalid_o,
    output logic [N_MASTERS-1:0]          m_ready_o,
    output logic                          s_avalid_o,
    output logic [ADDR_W-1:0]             s_addr_o,
    output logic [DATA_W-1:0]             s_wdata_o,
    output logic [DATA_W/8-1:0]           s_wstrb_o,
    input  logic [DATA_W-1:0]             s_rdata_i,
    input  logic                          s_rvalid_i,
    input  logic                          s_ready_i,
    output logic                          err_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int PTR_W  = $clog2(RD_FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    logic [IDX_W-1:0]  r_last;
    logic [IDX_W-1:0]  r_ids [RD_FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_err;

    logic [IDX_W-1:0]  w_g;
    logic              w_any;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [STRB_W-1:0] w_wstrb;
    logic              w_isRd;
    logic              w_full;
    logic              w_empty;
    logic              w_blk;
    logic              w_acc;
    logic              w_push;
    logic              w_pop;
    logic              w_stray;
    logic [IDX_W-1:0]  w_head;

    // Round-robin pick: the requester closest above the last winner (with wrap) wins.
    always_comb begin
        int wDist;
        int wBest;
        w_g   = '0;
        wDist = 0;
        wBest = N_MASTERS;
        for (int k = 0; k < N_MASTERS; k++) begin
            wDist = (k + N_MASTERS - 1 - int'(r_last)) % N_MASTERS;
            if (m_avalid_i[k] && (wDist < wBest)) begin
                wBest = wDist;
                w_g   = IDX_W'(k);
            end
        end
    end

    // Route the granted master's request fields; idle bus shows all zeros.
    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_wstrb = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (w_any && (w_g == IDX_W'(k))) begin
                w_addr  = m_addr_i[k*ADDR_W +: ADDR_W];
                w_wdata = m_wdata_i[k*DATA_W +: DATA_W];
                w_wstrb = m_wstrb_i[k*STRB_W +: STRB_W];
            end
        end
    end

    assign w_any   = |m_avalid_i;
    assign w_isRd  = (w_wstrb == '0);
    assign w_full  = (r_count == CNT_W'(RD_FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    // A read with no room for its ID stalls everything; full blocks push even
    // when a pop coincides, keeping s_rvalid_i off the s_avalid_o path.
    assign w_blk   = w_isRd & w_full;
    assign w_acc   = s_avalid_o & s_ready_i;
    assign w_push  = w_acc & w_isRd;
    assign w_pop   = s_rvalid_i & ~w_empty & ~rst_i;
    assign w_stray = s_rvalid_i & w_empty;
    assign w_head  = r_ids[r_rptr];

    assign s_avalid_o = w_any & ~w_blk & ~rst_i;
    assign s_addr_o   = w_addr;
    assign s_wdata_o  = w_wdata;
    assign s_wstrb_o  = w_wstrb;
    assign err_o      = r_err;

    // Per-master handshake and response steering back to the FIFO head's owner.
    always_comb begin
        m_ready_o  = '0;
        m_rvalid_o = '0;
        m_rdata_o  = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (w_acc && (w_g == IDX_W'(k))) begin
                m_ready_o[k] = 1'b1;
            end
            if (w_pop && (w_head == IDX_W'(k))) begin
                m_rvalid_o[k]                  = 1'b1;
                m_rdata_o[k*DATA_W +: DATA_W]  = s_rdata_i;
            end
        end
    end

    // Priority pointer, FIFO pointers/count and sticky error flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last  <= IDX_W'(N_MASTERS - 1);
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_acc) begin
                r_last <= w_g;
            end
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_stray) begin
                r_err <= 1'b1;
            end
        end
    end

    // ID storage needs no reset: entries are only read once pushed.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_ids[r_wptr] <= w_g;
        end
    end

endmodule

// File: tb/tb_iob_rr_arbiter.sv
// Bench for iob_rr_arbiter: directed sequences with literal expectations,
// plus a queue-based reference model checked on every falling edge.
module tb_iob_rr_arbiter;

    localparam int N     = 2;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    bit          clk;
    logic        rst_i;
    logic [N-1:0]        m_avalid_i;
    logic [N*AW-1:0]     m_addr_i;
    logic [N*DW-1:0]     m_wdata_i;
    logic [N*DW/8-1:0]   m_wstrb_i;
    logic [N*DW-1:0]     m_rdata_o;
    logic [N-1:0]        m_rvalid_o;
    logic [N-1:0]        m_ready_o;
    logic                s_avalid_o;
    logic [AW-1:0]       s_addr_o;
    logic [DW-1:0]       s_wdata_o;
    logic [DW/8-1:0]     s_wstrb_o;
    logic [DW-1:0]       s_rdata_i;
    logic                s_rvalid_i;
    logic                s_ready_i;
    logic                err_o;

    int errCount   = 0;
    int checkCount = 0;

    iob_rr_arbiter #(
        .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .RD_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m_avalid_i(m_avalid_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
        .m_wstrb_i(m_wstrb_i), .m_rdata_o(m_rdata_o), .m_rvalid_o(m_rvalid_o),
        .m_ready_o(m_ready_o), .s_avalid_o(s_avalid_o), .s_addr_o(s_addr_o),
        .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o), .s_rdata_i(s_rdata_i),
        .s_rvalid_i(s_rvalid_i), .s_ready_i(s_ready_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: last winner index, queue of outstanding read owners, sticky error.
    int   mLast = N - 1;
    int   mQ[$];
    bit   mErr = 0;

    always @(negedge clk) begin
        if ($time > 6) begin
            int   g;
            bit   found;
            bit   isRd;
            bit   expAvalid;
            bit   expAcc;
            bit   pop;
            int   head;
            logic [63:0] expRdy;
            logic [63:0] expRv;
            logic [63:0] expRdata;
            g = 0;
            found = 0;
            for (int off = 1; off <= N; off++) begin
                int idx;
                idx = (mLast + off) % N;
                if (!found && (((m_avalid_i >> idx) & 1) != 0)) begin
                    found = 1;
                    g = idx;
                end
            end
            isRd      = found && (4'(m_wstrb_i >> (g * 4)) == 4'h0);
            expAvalid = !rst_i && found && !(isRd && mQ.size() == DEPTH);
            expAcc    = expAvalid && s_ready_i;
            expRdy    = expAcc ? (64'd1 << g) : 64'd0;
            pop       = !rst_i && s_rvalid_i && (mQ.size() > 0);
            head      = (mQ.size() > 0) ? mQ[0] : 0;
            expRv     = pop ? (64'd1 << head) : 64'd0;
            expRdata  = 64'(s_rdata_i) << (head * DW);

            checkOutput("model s_avalid", 64'(s_avalid_o), 64'(expAvalid));
            checkOutput("model m_ready", 64'(m_ready_o), expRdy);
            checkOutput("model m_rvalid", 64'(m_rvalid_o), expRv);
            checkOutput("model err", 64'(err_o), 64'(mErr));
            checkOutput("model s_addr", 64'(s_addr_o), found ? 64'(32'(m_addr_i >> (g * AW))) : 64'd0);
            checkOutput("model s_wdata", 64'(s_wdata_o), found ? 64'(32'(m_wdata_i >> (g * DW))) : 64'd0);
            checkOutput("model s_wstrb", 64'(s_wstrb_o), found ? 64'(4'(m_wstrb_i >> (g * 4))) : 64'd0);
            if (pop) begin
                checkOutput("model m_rdata", 64'(m_rdata_o), expRdata);
            end

            if (rst_i) begin
                mLast = N - 1;
                mQ.delete();
                mErr = 0;
            end else begin
                if (expAcc) mLast = g;
                if (pop) void'(mQ.pop_front());
                else if (s_rvalid_i) mErr = 1;
                if (expAcc && isRd) mQ.push_back(g);
            end
        end
    end

    // Drive one cycle of inputs just after the rising edge; callers check 2ns later.
    task automatic applyStimulus(input logic [1:0] av, input logic [3:0] st0, input logic [3:0] st1,
                                 input logic [31:0] addr0, input logic srdy, input logic srv,
                                 input logic [31:0] srd);
        @(posedge clk);
        #1;
        m_avalid_i = av;
        m_wstrb_i  = {st1, st0};
        m_addr_i   = {addr0 + 32'h1000, addr0};
        m_wdata_i  = {~addr0, addr0 ^ 32'h5A5A_5A5A};
        s_ready_i  = srdy;
        s_rvalid_i = srv;
        s_rdata_i  = srd;
        #2;
    endtask

    task automatic idle();
        applyStimulus(2'b00, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst_i      = 1'b1;
        m_avalid_i = 2'b11;
        m_wstrb_i  = '0;
        s_ready_i  = 1'b1;
        s_rvalid_i = 1'b1;
        #2;
        checkOutput("reset s_avalid", 64'(s_avalid_o), 64'd0);
        checkOutput("reset m_ready", 64'(m_ready_o), 64'd0);
        checkOutput("reset m_rvalid", 64'(m_rvalid_o), 64'd0);
        @(posedge clk);
        #1;
        rst_i      = 1'b0;
        m_avalid_i = '0;
        s_rvalid_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; m_avalid_i = '0; m_addr_i = '0; m_wdata_i = '0; m_wstrb_i = '0;
        s_rdata_i = '0; s_rvalid_i = 1'b0; s_ready_i = 1'b0;
        doReset();
        idle();
        checkOutput("reset err", 64'(err_o), 64'd0);

        $display("[TB] single read");
        applyStimulus(2'b01, 4'h0, 4'h0, 32'h10, 1'b1, 1'b0, 32'h0);
        checkOutput("rd s_avalid", 64'(s_avalid_o), 64'd1);
        checkOutput("rd m_ready", 64'(m_ready_o), 64'h1);
        checkOutput("rd s_addr", 64'(s_addr_o), 64'h10);
        idle();
        applyStimulus(2'b00, 4'h0, 4'h0, 32'h0, 1'b1, 1'b1, 32'hCAFE);
        checkOutput("rd m_rvalid", 64'(m_rvalid_o), 64'h1);
        checkOutput("rd m0 rdata", 64'(m_rdata_o[31:0]), 64'hCAFE);
        checkOutput("rd m1 rdata", 64'(m_rdata_o[63:32]), 64'h0);

        $display("[TB] round robin");
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b11, 4'hF, 4'h3, 32'h100 + 32'(i), 1'b1, 1'b0, 32'h0);
            checkOutput("rr grant", 64'(m_ready_o), (i % 2 == 0) ? 64'h1 : 64'h2);
        end
        doReset();
        applyStimulus(2'b10, 4'h0, 4'hF, 32'h200, 1'b1, 1'b0, 32'h0);
        checkOutput("rr m1 only", 64'(m_ready_o), 64'h2);

        $display("[TB] interleaved reads");
        doReset();
        applyStimulus(2'b11, 4'h0, 4'h0, 32'h300, 1'b1, 1'b0, 32'h0);
        checkOutput("il grant0", 64'(m_ready_o), 64'h1);
        applyStimulus(2'b11, 4'h0, 4'h0, 32'h304, 1'b1, 1'b0, 32'h0);
        checkOutput("il grant1", 64'(m_ready_o), 64'h2);
        applyStimulus(2'b01, 4'h0, 4'h0, 32'h308, 1'b1, 1'b0, 32'h0);
        checkOutput("il grant2", 64'(m_ready_o), 64'h1);
        applyStimulus(2'b00, 4'h0, 4'h0, 32'h0, 1'b1, 1'b1, 32'hA);
        checkOutput("il rv A", 64'(m_rvalid_o), 64'h1);
        checkOutput("il data A", 64'(m_rdata_o[31:0]), 64'hA);
        applyStimulus(2'b00, 4'h0, 4'h0, 32'h0, 1'b1, 1'b1, 32'hB);
        checkOutput("il rv B", 64'(m_rvalid_o), 64'h2);
        checkOutput("il data B", 64'(m_rdata_o[63:32]), 64'hB);
        applyStimulus(2'b00, 4'h0, 4'h0, 32'h0, 1'b1, 1'b1, 32'hC);
        checkOutput("il rv C", 64'(m_rvalid_o), 64'h1);
        checkOutput("il data C", 64'(m_rdata_o[31:0]), 64'hC);

        $display("[TB] fifo full");
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b11, 4'h0, 4'h0, 32'h400 + 32'(i * 4), 1'b1, 1'b0, 32'h0);
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(2'b11, 4'h0, 4'hF, 32'h440, 1'b1, 1'b0, 32'h0);
            checkOutput("full s_avalid", 64'(s_avalid_o), 64'd0);
            checkOutput("full m_ready", 64'(m_ready_o), 64'd0);
        end
        applyStimulus(2'b11, 4'h0, 4'hF, 32'h440, 1'b1, 1'b1, 32'h11);
        checkOutput("full pop s_avalid", 64'(s_avalid_o), 64'd0);
        checkOutput("full pop rvalid", 64'(m_rvalid_o), 64'h1);
        applyStimulus(2'b11, 4'h0, 4'hF, 32'h440, 1'b1, 1'b0, 32'h0);
        checkOutput("full 5th read", 64'(m_ready_o), 64'h1);
        applyStimulus(2'b10, 4'h0, 4'hF, 32'h440, 1'b1, 1'b0, 32'h0);
        checkOutput("full write", 64'(m_ready_o), 64'h2);
        applyStimulus(2'b00, 4'h0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h22);
        checkOutput("drain head", 64'(m_rvalid_o), 64'h2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b00, 4'h0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h33 + 32'(i));
        end

        $display("[TB] slave stall");
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b11, 4'hF, 4'hF, 32'h500, 1'b0, 1'b0, 32'h0);
            checkOutput("stall m_ready", 64'(m_ready_o), 64'd0);
            checkOutput("stall s_avalid", 64'(s_avalid_o), 64'd1);
        end
        applyStimulus(2'b11, 4'hF, 4'hF, 32'h500, 1'b1, 1'b0, 32'h0);
        checkOutput("stall release", 64'(m_ready_o), 64'h1);
        applyStimulus(2'b10, 4'hF, 4'hF, 32'h500, 1'b1, 1'b0, 32'h0);
        checkOutput("stall next", 64'(m_ready_o), 64'h2);

        $display("[TB] errors and reset");
        doReset();
        applyStimulus(2'b00, 4'h0, 4'h0, 32'h0, 1'b1, 1'b1, 32'hDEAD);
        checkOutput("stray rvalid", 64'(m_rvalid_o), 64'd0);
        idle();
        checkOutput("err set", 64'(err_o), 64'd1);
        idle();
        checkOutput("err sticky", 64'(err_o), 64'd1);
        applyStimulus(2'b01, 4'h0, 4'h0, 32'h600, 1'b1, 1'b0, 32'h0);
        applyStimulus(2'b01, 4'h0, 4'h0, 32'h604, 1'b1, 1'b0, 32'h0);
        doReset();
        idle();
        checkOutput("err cleared", 64'(err_o), 64'd0);
        applyStimulus(2'b11, 4'hF, 4'hF, 32'h700, 1'b1, 1'b0, 32'h0);
        checkOutput("post-reset prio", 64'(m_ready_o), 64'h1);
        applyStimulus(2'b00, 4'h0, 4'h0, 32'h0, 1'b1, 1'b1, 32'hBEEF);
        checkOutput("stale rvalid", 64'(m_rvalid_o), 64'd0);
        idle();
        checkOutput("err again", 64'(err_o), 64'd1);

        idle();
        idle();
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/iob_rr_arbiter.md
Name: iob_rr_arbiter

Overview:
- N-master to 1-slave IOb native bus arbiter with round-robin grant and in-order read-response routing.
- Sits in front of the external-memory bridge: the instruction/data cache back-ends and other masters share the single IOb-to-AXI path.
- Tracks outstanding reads in an ID FIFO, so a new request can issue before earlier read data returns.
- Each read response is steered to the master that issued the read.

Parameters:
- N_MASTERS, 2, number of requesting masters (>=2).
- ADDR_W, 32, address width.
- DATA_W, 32, data width (multiple of 8).
- RD_FIFO_DEPTH, 4, max outstanding reads (power of two, >=2).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- m_avalid_i  in  N_MASTERS  per-master request valid
- m_addr_i  in  N_MASTERS*ADDR_W  per-master address; master k at slice k
- m_wdata_i  in  N_MASTERS*DATA_W  per-master write data
- m_wstrb_i  in  N_MASTERS*DATA_W/8  per-master byte strobes; all-zero means read
- m_rdata_o  out  N_MASTERS*DATA_W  per-master read data
- m_rvalid_o  out  N_MASTERS  per-master read-data valid
- m_ready_o  out  N_MASTERS  per-master request accepted
- s_avalid_o  out  1  slave request valid
- s_addr_o  out  ADDR_W  slave address
- s_wdata_o  out  DATA_W  slave write data
- s_wstrb_o  out  DATA_W/8  slave strobes
- s_rdata_i  in  DATA_W  slave read data
- s_rvalid_i  in  1  slave read-data valid, in order
- s_ready_i  in  1  slave accepts request
- err_o  out  1  sticky protocol error

Behaviour:
- Masters hold avalid/addr/wdata/wstrb stable until their m_ready_o is seen.
- Grant is combinational in the same cycle:
  - Search m_avalid_i starting from index last_q+1 mod N_MASTERS, upward with wrap.
  - The first set bit is g.
- Slave-side request signals:
  - s_addr_o, s_wdata_o and s_wstrb_o take master g's slice.
  - These outputs are 0 when no request is pending.
- Read/write classification and blocking:
  - is_rd = (wstrb of g == 0).
  - blk = is_rd & fifo_full.
  - s_avalid_o = any(m_avalid_i) & ~blk.
- Ready: m_ready_o[g] = s_ready_i & s_avalid_o. All other m_ready_o bits are 0.
- Blocking detail:
  - A blocked read stalls the whole arbiter; no other master is considered.
  - No read-bypass or write-bypass.
- Accept: acc = s_avalid_o & s_ready_i. Zero-cycle latency from master to slave.
- Pointer update: on acc, last_q <= g. Otherwise last_q holds.
- ID FIFO:
  - On acc & is_rd, push g.
  - On s_rvalid_i with FIFO not empty, pop the head h.
  - m_rvalid_o[h] = s_rvalid_i, same cycle. m_rdata_o slice h = s_rdata_i.
  - Other rdata slices read as 0, as do all rvalid bits other than h.
- FIFO full/empty:
  - Full means count == RD_FIFO_DEPTH.
  - Simultaneous push and pop is allowed when not full; count is unchanged.
  - When full, push is blocked even if a pop happens in the same cycle. This avoids a combinational path from s_rvalid_i to s_avalid_o.
- Counter widths:
  - Count is log2(RD_FIFO_DEPTH)+1 bits.
  - Read and write pointers are log2(RD_FIFO_DEPTH) bits and wrap naturally.
- Writes produce no rvalid and never touch the FIFO.
- Protocol error:
  - s_rvalid_i while the FIFO is empty sets err_o.
  - The response is dropped; no m_rvalid_o is asserted.
  - err_o clears only on reset.
- Reset (rst_i high at a clk_i edge):
  - last_q = N_MASTERS-1, so master 0 has top priority first.
  - FIFO emptied; err_o = 0.
  - While rst_i is high: s_avalid_o, all m_ready_o and all m_rvalid_o are forced to 0.
- Reset mid-operation:
  - Outstanding read IDs are discarded.
  - Any later s_rvalid_i for them sets err_o.
  - The system must reset the slave together with this block.

Test Plan:
- Single read: m0 reads addr 0x10, s_ready_i=1 → s_avalid_o/m_ready_o[0] same cycle. Slave rvalid 2 cycles later with 0xCAFE → m_rvalid_o[0]=1, m0 rdata=0xCAFE, m1 rvalid=0.
- Round robin: both masters issue continuous writes, s_ready_i=1 → grants 0,1,0,1. With only m1 active after reset → m1 granted immediately.
- Interleaved reads: m0 read, m1 read, m0 read back-to-back. Slave returns 0xA, 0xB, 0xC in order → delivered to m0, m1, m0 respectively.
- FIFO full: 4 reads accepted with no rvalid, 5th read → s_avalid_o=0, m_ready_o=0. A pending write behind it is also stalled. One rvalid → 5th read accepted next cycle.
- Slave stall: s_ready_i=0 for 3 cycles with m0 and m1 pending → no ready, no pointer change. s_ready_i=1 → m0 accepted first (post-reset priority).
- Errors/reset: rvalid with empty FIFO → err_o=1 and stays. Reset with 2 reads outstanding → err_o=0, FIFO empty, m0 highest priority; a later stray rvalid sets err_o again.
